// File: rtl/mem_wb_pipeline_if.sv
// Data-memory request/response bus between the M stage and the data memory.
// The master issues requests; the slave (memory) answers with ready and load data.
interface mem_wb_pipeline_if #(
    parameter int unsigned DATA_W = 32
);
    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memReady;
    logic [DATA_W-1:0] memRdata;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memReady, memRdata
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memReady, memRdata
    );
endinterface

// File: rtl/mem_wb_pipeline.sv
// M/W pipeline registers with data-memory handshake, load stall and stall counter.
// Handshake outputs are combinational from the M register; W outputs are registered.
module mem_wb_pipeline #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validE,
    input  logic              regWriteE,
    input  logic              memReadE,
    input  logic              memWriteE,
    input  logic [REG_W-1:0]  rd_E,
    input  logic [DATA_W-1:0] aluResultE,
    input  logic [DATA_W-1:0] storeDataE,
    input  logic              flushM,
    output logic              readyE,
    mem_wb_pipeline_if.master mem,
    output logic              regWriteM,
    output logic              memReadM,
    output logic [REG_W-1:0]  rd_M,
    output logic [DATA_W-1:0] fwdDataM,
    output logic              regWriteW,
    output logic [REG_W-1:0]  rd_W,
    output logic [DATA_W-1:0] wbDataW,
    output logic              memStall,
    output logic [CNT_W-1:0]  stallCount
);

    logic              valid_m_q,     valid_m_d;
    logic              reg_write_m_q, reg_write_m_d;
    logic              mem_read_m_q,  mem_read_m_d;
    logic              mem_write_m_q, mem_write_m_d;
    logic [REG_W-1:0]  rd_m_q,        rd_m_d;
    logic [DATA_W-1:0] alu_m_q,       alu_m_d;
    logic [DATA_W-1:0] store_m_q,     store_m_d;

    logic              valid_w_q,     valid_w_d;
    logic              reg_write_w_q, reg_write_w_d;
    logic [REG_W-1:0]  rd_w_q,        rd_w_d;
    logic [DATA_W-1:0] wb_data_w_q,   wb_data_w_d;

    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;

    logic is_mem;
    logic m_done;

    // Handshake decode straight off the M register.
    assign is_mem   = valid_m_q & (mem_read_m_q | mem_write_m_q);
    assign memStall = is_mem & ~mem.memReady & ~flushM;
    assign m_done   = valid_m_q & ~memStall & ~flushM;
    assign readyE   = ~memStall;

    assign mem.memReq   = is_mem;
    assign mem.memWe    = is_mem & mem_write_m_q;
    assign mem.memAddr  = alu_m_q;
    assign mem.memWdata = store_m_q;

    // Qualified enables keep register 0 out of forwarding and writeback.
    assign regWriteM  = valid_m_q & reg_write_m_q & (rd_m_q != '0);
    assign memReadM   = valid_m_q & mem_read_m_q;
    assign rd_M       = rd_m_q;
    assign fwdDataM   = alu_m_q;
    assign regWriteW  = valid_w_q & reg_write_w_q & (rd_w_q != '0);
    assign rd_W       = rd_w_q;
    assign wbDataW    = wb_data_w_q;
    assign stallCount = stall_cnt_q;

    // Next-state for M, W and the stall counter.
    always_comb begin
        valid_m_d     = valid_m_q;
        reg_write_m_d = reg_write_m_q;
        mem_read_m_d  = mem_read_m_q;
        mem_write_m_d = mem_write_m_q;
        rd_m_d        = rd_m_q;
        alu_m_d       = alu_m_q;
        store_m_d     = store_m_q;
        valid_w_d     = 1'b0;
        reg_write_w_d = reg_write_w_q;
        rd_w_d        = rd_w_q;
        wb_data_w_d   = wb_data_w_q;
        stall_cnt_d   = stall_cnt_q;

        if (flushM) begin
            valid_m_d = 1'b0;
        end else if (!memStall) begin
            valid_m_d     = validE;
            reg_write_m_d = regWriteE;
            mem_read_m_d  = memReadE;
            mem_write_m_d = memWriteE;
            rd_m_d        = rd_E;
            alu_m_d       = aluResultE;
            store_m_d     = storeDataE;
        end

        if (m_done) begin
            valid_w_d     = 1'b1;
            reg_write_w_d = reg_write_m_q;
            rd_w_d        = rd_m_q;
            wb_data_w_d   = mem_read_m_q ? mem.memRdata : alu_m_q;
        end

        if (memStall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_m_q     <= 1'b0;
            reg_write_m_q <= 1'b0;
            mem_read_m_q  <= 1'b0;
            mem_write_m_q <= 1'b0;
            rd_m_q        <= '0;
            alu_m_q       <= '0;
            store_m_q     <= '0;
            valid_w_q     <= 1'b0;
            reg_write_w_q <= 1'b0;
            rd_w_q        <= '0;
            wb_data_w_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            valid_m_q     <= valid_m_d;
            reg_write_m_q <= reg_write_m_d;
            mem_read_m_q  <= mem_read_m_d;
            mem_write_m_q <= mem_write_m_d;
            rd_m_q        <= rd_m_d;
            alu_m_q       <= alu_m_d;
            store_m_q     <= store_m_d;
            valid_w_q     <= valid_w_d;
            reg_write_w_q <= reg_write_w_d;
            rd_w_q        <= rd_w_d;
            wb_data_w_q   <= wb_data_w_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipeline.sv
// Directed bench for mem_wb_pipeline: inputs driven and outputs sampled on the falling edge.
module tb_mem_wb_pipeline;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              validE, regWriteE, memReadE, memWriteE;
    logic [REG_W-1:0]  rd_E;
    logic [DATA_W-1:0] aluResultE, storeDataE;
    logic              flushM;
    logic              readyE;
    logic              regWriteM, memReadM;
    logic [REG_W-1:0]  rd_M;
    logic [DATA_W-1:0] fwdDataM;
    logic              regWriteW;
    logic [REG_W-1:0]  rd_W;
    logic [DATA_W-1:0] wbDataW;
    logic              memStall;
    logic [CNT_W-1:0]  stallCount;

    int n_chk;
    int n_pass;

    mem_wb_pipeline_if #(.DATA_W(DATA_W)) mem_bus ();

    mem_wb_pipeline #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .validE     (validE),
        .regWriteE  (regWriteE),
        .memReadE   (memReadE),
        .memWriteE  (memWriteE),
        .rd_E       (rd_E),
        .aluResultE (aluResultE),
        .storeDataE (storeDataE),
        .flushM     (flushM),
        .readyE     (readyE),
        .mem        (mem_bus.master),
        .regWriteM  (regWriteM),
        .memReadM   (memReadM),
        .rd_M       (rd_M),
        .fwdDataM   (fwdDataM),
        .regWriteW  (regWriteW),
        .rd_W       (rd_W),
        .wbDataW    (wbDataW),
        .memStall   (memStall),
        .stallCount (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_ex();
        validE     = 1'b0;
        regWriteE  = 1'b0;
        memReadE   = 1'b0;
        memWriteE  = 1'b0;
        rd_E       = '0;
        aluResultE = '0;
        storeDataE = '0;
    endtask

    task automatic alu_op(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] val);
        validE     = 1'b1;
        regWriteE  = 1'b1;
        memReadE   = 1'b0;
        memWriteE  = 1'b0;
        rd_E       = rd;
        aluResultE = val;
        storeDataE = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        flushM = 1'b0;
        mem_bus.memReady = 1'b0;
        mem_bus.memRdata = '0;
        idle_ex();
        repeat (2) step();
        reset = 1'b1;
        step();

        // Reset then idle
        chk("rst_regWriteM", 32'(regWriteM), 32'h0);
        chk("rst_regWriteW", 32'(regWriteW), 32'h0);
        chk("rst_memReq",    32'(mem_bus.memReq), 32'h0);
        chk("rst_memStall",  32'(memStall), 32'h0);
        chk("rst_readyE",    32'(readyE), 32'h1);
        chk("rst_stallCount", 32'(stallCount), 32'h0);

        // ALU op rd=5
        alu_op(5'd5, 32'h1234);
        step();
        idle_ex();
        chk("alu_regWriteM", 32'(regWriteM), 32'h1);
        chk("alu_rd_M",      32'(rd_M), 32'h5);
        chk("alu_fwdDataM",  fwdDataM, 32'h1234);
        chk("alu_memReq",    32'(mem_bus.memReq), 32'h0);
        step();
        chk("alu_regWriteW", 32'(regWriteW), 32'h1);
        chk("alu_rd_W",      32'(rd_W), 32'h5);
        chk("alu_wbDataW",   wbDataW, 32'h1234);
        chk("alu_regWriteM_gone", 32'(regWriteM), 32'h0);

        // Load with memReady on the 3rd request cycle; younger op waits in EX
        validE = 1'b1; regWriteE = 1'b1; memReadE = 1'b1; rd_E = 5'd7; aluResultE = 32'h100;
        step();
        alu_op(5'd9, 32'h99);
        #1;
        chk("ld_memReq",   32'(mem_bus.memReq), 32'h1);
        chk("ld_memWe",    32'(mem_bus.memWe), 32'h0);
        chk("ld_memAddr",  mem_bus.memAddr, 32'h100);
        chk("ld_memReadM", 32'(memReadM), 32'h1);
        chk("ld_stall1",   32'(memStall), 32'h1);
        chk("ld_readyE1",  32'(readyE), 32'h0);
        step();
        chk("ld_stall2",   32'(memStall), 32'h1);
        chk("ld_readyE2",  32'(readyE), 32'h0);
        chk("ld_cnt1",     32'(stallCount), 32'h1);
        chk("ld_rd_M_held", 32'(rd_M), 32'h7);
        step();
        mem_bus.memReady = 1'b1;
        mem_bus.memRdata = 32'hCAFE;
        #1;
        chk("ld_stall3",   32'(memStall), 32'h0);
        chk("ld_readyE3",  32'(readyE), 32'h1);
        chk("ld_cnt2_pre", 32'(stallCount), 32'h2);
        step();
        mem_bus.memReady = 1'b0;
        mem_bus.memRdata = '0;
        idle_ex();
        chk("ld_wbDataW",   wbDataW, 32'hCAFE);
        chk("ld_rd_W",      32'(rd_W), 32'h7);
        chk("ld_regWriteW", 32'(regWriteW), 32'h1);
        chk("ld_stallCount", 32'(stallCount), 32'h2);
        chk("ld_next_rd_M", 32'(rd_M), 32'h9);
        chk("ld_next_fwd",  fwdDataM, 32'h99);
        step();
        chk("ld_next_rd_W", 32'(rd_W), 32'h9);
        chk("ld_next_wb",   wbDataW, 32'h99);

        // rd=0 never qualifies a write
        alu_op(5'd0, 32'h55);
        step();
        idle_ex();
        chk("r0_regWriteM", 32'(regWriteM), 32'h0);
        chk("r0_fwdDataM",  fwdDataM, 32'h55);
        step();
        chk("r0_regWriteW", 32'(regWriteW), 32'h0);
        chk("r0_wbDataW",   wbDataW, 32'h55);

        // Flush while a load waits on memory
        validE = 1'b1; regWriteE = 1'b1; memReadE = 1'b1; rd_E = 5'd3; aluResultE = 32'h200;
        step();
        idle_ex();
        #1;
        chk("fl_stall", 32'(memStall), 32'h1);
        step();
        flushM = 1'b1;
        alu_op(5'd12, 32'h777);
        #1;
        chk("fl_readyE",   32'(readyE), 32'h1);
        chk("fl_memStall", 32'(memStall), 32'h0);
        chk("fl_memReq_same_cycle", 32'(mem_bus.memReq), 32'h1);
        step();
        flushM = 1'b0;
        idle_ex();
        chk("fl_memReq_dropped", 32'(mem_bus.memReq), 32'h0);
        chk("fl_ex_not_in_M",    32'(regWriteM), 32'h0);
        chk("fl_rd_M_not_ex",    32'(rd_M), 32'h3);
        chk("fl_regWriteW",      32'(regWriteW), 32'h0);
        chk("fl_wbDataW_hold",   wbDataW, 32'h55);
        chk("fl_stallCount",     32'(stallCount), 32'h3);
        step();
        chk("fl_regWriteW_after", 32'(regWriteW), 32'h0);
        chk("fl_rd_W_hold",       32'(rd_W), 32'h0);

        // Single-cycle store: no stall, no writeback
        validE = 1'b1; memWriteE = 1'b1; aluResultE = 32'h300; storeDataE = 32'hBEEF; rd_E = 5'd4;
        step();
        idle_ex();
        mem_bus.memReady = 1'b1;
        #1;
        chk("st_memReq",   32'(mem_bus.memReq), 32'h1);
        chk("st_memWe",    32'(mem_bus.memWe), 32'h1);
        chk("st_memAddr",  mem_bus.memAddr, 32'h300);
        chk("st_memWdata", mem_bus.memWdata, 32'hBEEF);
        chk("st_memStall", 32'(memStall), 32'h0);
        step();
        mem_bus.memReady = 1'b0;
        chk("st_regWriteW",  32'(regWriteW), 32'h0);
        chk("st_memReq_off", 32'(mem_bus.memReq), 32'h0);
        chk("st_stallCount", 32'(stallCount), 32'h3);

        // Back-to-back ALU ops rd 1..4 reach W in consecutive cycles
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                chk("b2b_regWriteW", 32'(regWriteW), 32'h1);
                chk("b2b_rd_W",      32'(rd_W), 32'(c - 1));
                chk("b2b_wbDataW",   wbDataW, 32'h10 * 32'(c - 1));
            end
            if (c < 4) alu_op(5'(c + 1), 32'h10 * 32'(c + 1));
            else idle_ex();
            step();
        end
        chk("b2b_bubble", 32'(regWriteW), 32'h0);

        // Reset mid-access drops the request at once
        validE = 1'b1; memReadE = 1'b1; regWriteE = 1'b1; rd_E = 5'd6; aluResultE = 32'h400;
        step();
        idle_ex();
        #1;
        chk("rm_memReq_before", 32'(mem_bus.memReq), 32'h1);
        reset = 1'b0;
        #1;
        chk("rm_memReq_after",  32'(mem_bus.memReq), 32'h0);
        chk("rm_memStall",      32'(memStall), 32'h0);
        chk("rm_stallCount",    32'(stallCount), 32'h0);
        chk("rm_wbDataW",       wbDataW, 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("rm_readyE", 32'(readyE), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
